// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Handshaked ALU for the MIPS EX stage, placed between the ID/EX operand
//   latches and the EX/MEM register. Single-cycle ops are computed
//   combinationally and land in the output register on the accepting edge.
//   mul runs in an iterative shift-add unit that holds in_ready low until the
//   product is written to the output register WIDTH cycles after accept.
//
// Parameters
//   WIDTH      operand/result width (>=4, power of two)
//   SHW        shift-amount bits, taken from in2[SHW-1:0]
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands/op presented
//   in_ready   unit can accept (transfer on in_valid & in_ready)
//   in1        operand A
//   in2        operand B / shift amount
//   aluop      operation select:
//                0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt, 7 sra,
//                8 xor, 9 nor, 10 sltu, 11 mul, 12-15 reserved (out=0)
//   out_valid  out/zeroflag/ovf hold a result
//   out_ready  consumer takes result on out_valid & out_ready
//   out        result
//   zeroflag   in1 == in2 of the accepted operation (beq compare)
//   ovf        signed overflow of add/sub, 0 for every other op
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zeroflag,
    output logic             ovf
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    // Step counter value during the final shift-add iteration.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             zf_q,        zf_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0] mplier_q,    mplier_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [SHW-1:0]   cnt_q,       cnt_d;

    logic             accept;

    // -------------------------------------------------------------------------
    // Single-cycle ALU datapath
    // -------------------------------------------------------------------------
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // NOTE: every signal written in an always_comb gets a default on entry, so
    // no path through the case statements can leave it unassigned (no latch).
    always_comb begin
        shamt   = in2[SHW-1:0];
        sum     = in1 + in2;
        diff    = in1 - in2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluop)
            OP_ADD: begin
                alu_res = sum;
                // Same-sign operands whose sum flips sign.
                alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                          (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                // Opposite-sign operands whose difference takes B's sign.
                alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                          (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_SLL:  alu_res = in1 << shamt;
            OP_SRL:  alu_res = in1 >> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SRA:  alu_res = $signed(in1) >>> shamt;
            OP_XOR:  alu_res = in1 ^ in2;
            OP_NOR:  alu_res = ~(in1 | in2);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            default: begin
                // mul is produced by the iterative unit; reserved codes give 0.
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A held result blocks new work unless the consumer takes it this cycle,
    // which lets single-cycle ops stream at full rate.
    assign in_ready = ~rst && (state_q == S_IDLE) && (~out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Shift-add multiplier step
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        zf_d        = zf_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    zf_d = (in1 == in2);
                    if (aluop == OP_MUL) begin
                        mcand_d     = in1;
                        mplier_d    = in2;
                        acc_d       = '0;
                        cnt_d       = '0;
                        // Any previous result was either empty or consumed on
                        // this edge; nothing is valid until the product lands.
                        out_valid_d = 1'b0;
                        state_d     = S_MUL;
                    end else begin
                        out_d       = alu_res;
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end

            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    out_d       = acc_next;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            zf_q        <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            zf_q        <= zf_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out       = out_q;
    assign zeroflag  = zf_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Directed bench for alu_pipe. A WIDTH=32 instance carries most scenarios; a
//   WIDTH=8 instance covers the narrow multiplier. Inputs are driven and outputs
//   sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in1, in2, out;
    logic [3:0]  aluop;
    logic        zeroflag, ovf;

    logic        n8_in_valid, n8_in_ready, n8_out_valid, n8_out_ready;
    logic [7:0]  n8_in1, n8_in2, n8_out;
    logic [3:0]  n8_aluop;
    logic        n8_zeroflag, n8_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .aluop(aluop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zeroflag(zeroflag), .ovf(ovf)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(n8_in_valid), .in_ready(n8_in_ready),
        .in1(n8_in1), .in2(n8_in2), .aluop(n8_aluop),
        .out_valid(n8_out_valid), .out_ready(n8_out_ready),
        .out(n8_out), .zeroflag(n8_zeroflag), .ovf(n8_ovf)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents a mul, waits for its result (bounded) and reports the cycle count
    // from accept to out_valid and how many of those cycles had in_ready high.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int n, output int rdy_seen);
        in_valid = 1'b1; aluop = 4'd11; in1 = a; in2 = b;
        step;
        in_valid = 1'b0;
        n = 0;
        rdy_seen = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_seen++;
            step;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; in1 = '0; in2 = '0; aluop = '0; out_ready = 1'b1;
        n8_in_valid = 1'b0; n8_in1 = '0; n8_in2 = '0; n8_aluop = '0; n8_out_ready = 1'b1;
        step;
        step;
        checks++;
        if ({in_ready, out_valid, out, zeroflag, ovf} !== 35'd0) begin
            errors++;
            $display("FAIL reset_hold rdy=%b vld=%b out=%h zf=%b ovf=%b exp all 0",
                     in_ready, out_valid, out, zeroflag, ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
        // Hold a result, then hit reset mid-cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; aluop = 4'd0; in1 = 32'd20; in2 = 32'd20;
        step;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== 32'd40 || zeroflag !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre vld=%b out=%h zf=%b exp vld=1 out=00000028 zf=1",
                     out_valid, out, zeroflag);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out, zeroflag, ovf} !== 35'd0) begin
            errors++;
            $display("FAIL reset_async rdy=%b vld=%b out=%h zf=%b ovf=%b exp all 0",
                     in_ready, out_valid, out, zeroflag, ovf);
        end
        step;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_basics;
        logic [3:0]  ops [9];
        logic [31:0] a   [9];
        logic [31:0] b   [9];
        logic [31:0] ex  [9];
        logic        ezf [9];
        ops = '{4'd0, 4'd1, 4'd1, 4'd6, 4'd5, 4'd2, 4'd3, 4'd8, 4'd9};
        a   = '{32'd10, 32'd10, 32'd5, 32'd1, 32'd1, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd0};
        b   = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'hFF00, 32'hFF00, 32'hFF00, 32'd0};
        ex  = '{32'd15, 32'd5, 32'd0, 32'd1, 32'd0, 32'hF000, 32'hFFF0, 32'h0FF0, 32'hFFFFFFFF};
        ezf = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; aluop = ops[i]; in1 = a[i]; in2 = b[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basics_ready[%0d] rdy=%b exp 1", i, in_ready);
            end
            step;
            checks++;
            if ({out_valid, out, zeroflag, ovf} !== {1'b1, ex[i], ezf[i], 1'b0}) begin
                errors++;
                $display("FAIL basics[%0d] vld=%b out=%h zf=%b ovf=%b exp vld=1 out=%h zf=%b ovf=0",
                         i, out_valid, out, zeroflag, ovf, ex[i], ezf[i]);
            end
        end
        in_valid = 1'b0;
        step;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basics_drain vld=%b exp 0", out_valid);
        end
    endtask

    task automatic test_signed_shift;
        logic [3:0]  ops [8];
        logic [31:0] a   [8];
        logic [31:0] b   [8];
        logic [31:0] ex  [8];
        logic        eov [8];
        ops = '{4'd0, 4'd6, 4'd10, 4'd7, 4'd4, 4'd1, 4'd0, 4'd5};
        a   = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                32'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        b   = '{32'd1, 32'd0, 32'd0, 32'd4, 32'h21, 32'd1, 32'd1, 32'hFFFFFF04};
        ex  = '{32'h80000000, 32'd1, 32'd0, 32'hF8000000,
                32'd2, 32'h7FFFFFFF, 32'd0, 32'h08000000};
        eov = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; aluop = ops[i]; in1 = a[i]; in2 = b[i];
            step;
            checks++;
            if ({out_valid, out, zeroflag, ovf} !== {1'b1, ex[i], 1'b0, eov[i]}) begin
                errors++;
                $display("FAIL signed[%0d] vld=%b out=%h zf=%b ovf=%b exp vld=1 out=%h zf=0 ovf=%b",
                         i, out_valid, out, zeroflag, ovf, ex[i], eov[i]);
            end
        end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_mul;
        int n;
        int rdy_seen;
        out_ready = 1'b1;
        run_mul(32'd7, 32'd6, n, rdy_seen);
        checks++;
        if (n !== 32 || rdy_seen !== 0) begin
            errors++;
            $display("FAIL mul7x6_timing cycles=%0d ready_cycles=%0d exp cycles=32 ready_cycles=0",
                     n, rdy_seen);
        end
        checks++;
        if ({out_valid, out, zeroflag, ovf} !== {1'b1, 32'd42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul7x6 vld=%b out=%h zf=%b ovf=%b exp vld=1 out=0000002a zf=0 ovf=0",
                     out_valid, out, zeroflag, ovf);
        end
        step;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_drain vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, n, rdy_seen);
        checks++;
        if (n !== 32 || {out, zeroflag, ovf} !== {32'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mul_ffff cycles=%0d out=%h zf=%b ovf=%b exp cycles=32 out=00000001 zf=1 ovf=0",
                     n, out, zeroflag, ovf);
        end
        step;
    endtask

    task automatic test_mul8;
        int n;
        int rdy_seen;
        n8_out_ready = 1'b1;
        n8_in_valid = 1'b1; n8_aluop = 4'd11; n8_in1 = 8'd15; n8_in2 = 8'd17;
        step;
        n8_in_valid = 1'b0;
        n = 0;
        rdy_seen = 0;
        while (!n8_out_valid && n < 100) begin
            if (n8_in_ready) rdy_seen++;
            step;
            n++;
        end
        checks++;
        if (n !== 8 || rdy_seen !== 0) begin
            errors++;
            $display("FAIL mul8_timing cycles=%0d ready_cycles=%0d exp cycles=8 ready_cycles=0",
                     n, rdy_seen);
        end
        checks++;
        if ({n8_out_valid, n8_out, n8_zeroflag, n8_ovf} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul8 vld=%b out=%h zf=%b ovf=%b exp vld=1 out=ff zf=0 ovf=0",
                     n8_out_valid, n8_out, n8_zeroflag, n8_ovf);
        end
        step;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid = 1'b1; aluop = 4'd0; in1 = 32'd3; in2 = 32'd4;
        step;
        // Second op stays presented while the consumer stalls.
        aluop = 4'd8; in1 = 32'd5; in2 = 32'd3;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out !== 32'd7 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] vld=%b out=%h rdy=%b exp vld=1 out=00000007 rdy=0",
                         k, out_valid, out, in_ready);
            end
            step;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release rdy=%b exp 1", in_ready);
        end
        step;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== 32'd6) begin
            errors++;
            $display("FAIL bp_second vld=%b out=%h exp vld=1 out=00000006", out_valid, out);
        end
        step;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain vld=%b exp 0", out_valid);
        end
    endtask

    task automatic test_abort_reserved;
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1; aluop = 4'd11; in1 = 32'd7; in2 = 32'd6;
        step;
        in_valid = 1'b0;
        repeat (10) step;
        rst = 1'b1;
        #2 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort valid_cycles=%0d rdy=%b exp valid_cycles=0 rdy=1", seen, in_ready);
        end
        // Nonzero result first so a reserved op visibly clears it.
        in_valid = 1'b1; aluop = 4'd0; in1 = 32'd2; in2 = 32'd3;
        step;
        aluop = 4'd13; in1 = 32'd9; in2 = 32'd9;
        step;
        checks++;
        if ({out_valid, out, zeroflag, ovf} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reserved13 vld=%b out=%h zf=%b ovf=%b exp vld=1 out=00000000 zf=1 ovf=0",
                     out_valid, out, zeroflag, ovf);
        end
        aluop = 4'd0; in1 = 32'h7FFFFFFF; in2 = 32'd1;
        step;
        aluop = 4'd12;
        step;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out, zeroflag, ovf} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reserved12 vld=%b out=%h zf=%b ovf=%b exp vld=1 out=00000000 zf=0 ovf=0",
                     out_valid, out, zeroflag, ovf);
        end
        step;
    endtask

    initial begin
        test_reset();
        test_basics();
        test_signed_shift();
        test_mul();
        test_mul8();
        test_backpressure();
        test_abort_reserved();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
